// File: rtl/gf256_pkg.sv
// Shared GF(2^8) definitions for the S-box datapath: reduction polynomial,
// inverter FSM state encoding and a reusable field multiply.
package gf256_pkg;

   // Low 8 bits of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
   localparam logic [7:0] GF_POLY = 8'h1B;

   // Inverter FSM state encoding.
   typedef logic [1:0] gf_state_t;
   localparam gf_state_t IDLE = 2'd0;
   localparam gf_state_t CALC = 2'd1;
   localparam gf_state_t DONE = 2'd2;

   // Carry-less 8x8 multiply reduced mod x^8+poly (shift-and-add, xtime per bit).
   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] poly);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = x[7] ? ((x << 1) ^ poly) : (x << 1);
      end
      return acc;
   endfunction

endpackage

// File: rtl/gf256_seq_inverse_if.sv
// Operand/result handshake bundle for gf256_seq_inverse.
// out_zero exists only when GF_INV_ZERO_FLAG_EN is defined.
interface gf256_seq_inverse_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;
`ifdef GF_INV_ZERO_FLAG_EN
   logic       out_zero;
`endif

   // Producer/consumer side (drives operands, accepts results).
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
`ifdef GF_INV_ZERO_FLAG_EN
      , input out_zero
`endif
   );

   // Inverter side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
`ifdef GF_INV_ZERO_FLAG_EN
      , output out_zero
`endif
   );
endinterface

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, p = a*b mod x^8+POLY.
// Explicit-instance wrapper around gf256_pkg::gf_mul.
module gf256_mul
   import gf256_pkg::*;
#(
   parameter logic [7:0] POLY = GF_POLY
) (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);

   assign p = gf_mul(a, b, POLY);

endmodule

// File: rtl/gf256_seq_inverse.sv
// Iterative GF(2^8) inverter: out = a^254 (a^-1, with 0 -> 0).
// Seven square-and-multiply steps through one squarer and one accumulator
// multiplier; valid/ready handshake on both sides.
// Optional feature macro: GF_INV_ZERO_FLAG_EN adds the out_zero flag.
module gf256_seq_inverse
   import gf256_pkg::*;
#(
   parameter logic [7:0] POLY = GF_POLY
) (
   input  logic                  clk,
   input  logic                  reset_n,
   gf256_seq_inverse_if.slave    bus
);

   gf_state_t  state;
   logic [2:0] cnt;
   logic [7:0] sq;
   logic [7:0] res;
   logic [7:0] s2;
   logic [7:0] res_nxt;
   logic       out_valid_r;
   logic       accept;
   logic       handoff;

   // sq^2, then res*sq^2: after step k, res = a^(2+4+...+2^k).
   gf256_mul #(.POLY(POLY)) u_square (.a(sq),  .b(sq), .p(s2));
   gf256_mul #(.POLY(POLY)) u_accum  (.a(res), .b(s2), .p(res_nxt));

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = res;

   assign accept  = bus.in_valid && (state == IDLE);
   assign handoff = out_valid_r && bus.out_ready;

   // FSM, step counter and square/accumulate registers; res doubles as the
   // registered result, frozen while in DONE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         sq          <= 8'h00;
         res         <= 8'h00;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sq    <= bus.in_data;
                  res   <= 8'h01;
                  cnt   <= 3'd0;
                  state <= CALC;
               end
            end
            CALC: begin
               sq  <= s2;
               res <= res_nxt;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd6) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (handoff) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef GF_INV_ZERO_FLAG_EN
   logic zero_r;
   assign bus.out_zero = zero_r;

   // Remember whether the accepted operand was zero; travels with the result.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         zero_r <= 1'b0;
      end else if (accept) begin
         zero_r <= (bus.in_data == 8'h00);
      end
   end
`endif

endmodule
